// File: rtl/riscv_mem_arbiter.sv
// Fetch / load-store arbiter sharing one single-port, byte-addressed memory; one access in flight.
// Optional performance counters are enabled by defining RISCV_MEM_ARB_PERF_EN.
module riscv_mem_arbiter #(
  parameter int WORD_LENGTH     = 32,
  parameter int ADDR_LENGTH     = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int MASK_SEL        = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_req,
  input  logic [ADDR_LENGTH-1:0] if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [WORD_LENGTH-1:0] if_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [ADDR_LENGTH-1:0] d_addr,
  input  logic [WORD_LENGTH-1:0] d_wdata,
  input  logic [MASK_SEL-1:0]    d_mask,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [WORD_LENGTH-1:0] d_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  output logic [MASK_SEL-1:0]    mem_mask_sel,
  input  logic                   mem_ready,
  input  logic                   mem_rvalid,
  input  logic [WORD_LENGTH-1:0] mem_rdata
`ifdef RISCV_MEM_ARB_PERF_EN
  ,
  output logic [31:0]            perf_if_grants,
  output logic [31:0]            perf_d_grants,
  output logic [31:0]            perf_stall_cycles
`endif
);

  // Lane-select encoding: MASK_B = 0, MASK_H = 1, MASK_X (full word) = 2.
  localparam logic [MASK_SEL-1:0] MASK_X = MASK_SEL'(2);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  state_t        state, state_nxt;
  owner_t        owner;
  logic [SW-1:0] streak;
  logic          d_win, f_win;

  function automatic logic [SW-1:0] streak_sat_inc(input logic [SW-1:0] s);
    return (s >= STREAK_MAX) ? STREAK_MAX : s + SW'(1);
  endfunction

  always_comb begin
    d_win     = 1'b0;
    f_win     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        d_win = d_req && (!if_req || (streak < STREAK_MAX));
        f_win = if_req && !d_win;
        if (d_win || f_win) state_nxt = REQ;
      end
      REQ:     if (mem_ready) state_nxt = mem_we ? IDLE : RESP;
      RESP:    if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are combinational; masking with rst_n keeps them low while reset is held.
  assign if_gnt = rst_n && f_win;
  assign d_gnt  = rst_n && d_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= OWN_FETCH;
      streak       <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_mask_sel <= MASK_X;
      if_rvalid    <= 1'b0;
      d_rvalid     <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;

      if (!if_req || f_win) streak <= '0;
      else if (d_win)       streak <= streak_sat_inc(streak);

      case (state)
        IDLE: begin
          if (d_win) begin
            owner        <= OWN_DATA;
            mem_en       <= 1'b1;
            mem_we       <= d_we;
            mem_addr     <= d_addr;
            mem_wdata    <= d_wdata;
            mem_mask_sel <= d_mask;
          end else if (f_win) begin
            owner        <= OWN_FETCH;
            mem_en       <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            mem_wdata    <= '0;
            mem_mask_sel <= MASK_X;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_en <= 1'b0;
            if (mem_we) begin
              d_rvalid <= 1'b1;
              d_rdata  <= '0;
            end
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            if (owner == OWN_DATA) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RISCV_MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_grants    <= '0;
      perf_d_grants     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (f_win) perf_if_grants <= perf_if_grants + 32'd1;
      if (d_win) perf_d_grants  <= perf_d_grants + 32'd1;
      if ((if_req || d_req) && (state != IDLE)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: cycle-level reference model plus a random-latency memory.
module tb_riscv_mem_arbiter;
  localparam int MAXS = 4;
  localparam logic [1:0] MB = 2'd0, MH = 2'd1, MX = 2'd2;

  typedef struct {
    bit          is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  logic if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0] d_mask, mem_mask_sel;
  logic mem_en, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef RISCV_MEM_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.WORD_LENGTH(32), .ADDR_LENGTH(32), .MAX_DATA_STREAK(MAXS), .MASK_SEL(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask_sel(mem_mask_sel), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef RISCV_MEM_ARB_PERF_EN
    , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Memory image; unmapped words read as an address hash.
  logic [31:0] mem_img [logic [31:0]];
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder knobs
  int rdy_lo = 0, rdy_hi = 0, rv_lo = 1, rv_hi = 1;
  bit noise = 0;

  initial begin
    int wait_c, rv_c;
    bit rd_pend;
    logic [31:0] rd_addr;
    wait_c = -1; rv_c = 0; rd_pend = 0; rd_addr = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (rd_pend) begin
        if (rv_c == 0) begin
          mem_rvalid = 1'b1; mem_rdata = mem_val(rd_addr); rd_pend = 0;
        end else rv_c--;
      end else if (noise && $urandom_range(3, 0) == 0) begin
        mem_rvalid = 1'b1; mem_rdata = $urandom;
      end
      mem_ready = 1'b0;
      if (mem_en) begin
        if (wait_c < 0) wait_c = int'($urandom_range(rdy_hi, rdy_lo));
        if (wait_c == 0) begin
          mem_ready = 1'b1; wait_c = -1;
          if (!mem_we) begin
            rd_pend = 1; rd_addr = mem_addr; rv_c = int'($urandom_range(rv_hi, rv_lo)) - 1;
          end
        end else wait_c--;
      end else begin
        wait_c = -1;
        if (noise) mem_ready = 1'($urandom_range(1, 0));
      end
    end
  end

  // Reference model state
  bit   busy, acc_done, rv_due;
  txn_t cur;
  int   streak_m, cyc;
  logic [31:0] last_if, last_d, last_mem_addr;
  bit   gf_s, gd_s;
  byte  gl[$];
  int   fg_m, dg_m, stall_m, en_cnt, if_rv_cnt, d_rv_cnt;
  int   t_gnt_f, t_gnt_d, t_rv_f, t_rv_d;

  // Requester stimulus
  logic [31:0] fq[$];
  txn_t dq[$];
  int f_gap = 0, d_gap = 0, f_gap_max = 0, d_gap_max = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    bit exp_d, exp_f;
    logic [31:0] ev;
    cyc++;
    gf_s = 0; gd_s = 0;
    if (!rst_n) begin
      chk("rst_ctl", {58'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we}, 64'd0);
      chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
      chk("rst_mem", {mem_addr, mem_wdata}, 64'd0);
      chk("rst_mask", mem_mask_sel, MX);
      busy = 0; acc_done = 0; rv_due = 0; streak_m = 0;
      last_if = '0; last_d = '0; fg_m = 0; dg_m = 0; stall_m = 0;
      return;
    end
    // responses
    chk("if_rvalid", if_rvalid, rv_due && !cur.is_d);
    chk("d_rvalid", d_rvalid, rv_due && cur.is_d);
    if (if_rvalid) begin if_rv_cnt++; t_rv_f = cyc; end
    if (d_rvalid) begin d_rv_cnt++; t_rv_d = cyc; end
    if (rv_due) begin
      ev = cur.we ? 32'd0 : mem_val(cur.addr);
      if (cur.is_d) last_d = ev; else last_if = ev;
      busy = 0; rv_due = 0;
    end
    chk("if_rdata", if_rdata, last_if);
    chk("d_rdata", d_rdata, last_d);
    if (busy && (if_req || d_req)) stall_m++;
    // memory side
    chk("mem_en", mem_en, busy && !acc_done);
    if (mem_en) begin
      en_cnt++; last_mem_addr = mem_addr;
      chk("mem_we", mem_we, cur.we);
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_mask", mem_mask_sel, cur.mask);
      if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
      if (mem_ready) begin
        acc_done = 1;
        if (cur.we) rv_due = 1;
      end
    end else if (busy && acc_done && !cur.we && !rv_due && mem_rvalid) rv_due = 1;
    // arbitration
    exp_d = !busy && d_req && (!if_req || streak_m < MAXS);
    exp_f = !busy && if_req && !exp_d;
    chk("if_gnt", if_gnt, exp_f);
    chk("d_gnt", d_gnt, exp_d);
    gf_s = if_gnt; gd_s = d_gnt;
    if (if_gnt) begin gl.push_back("F"); t_gnt_f = cyc; end
    if (d_gnt) begin gl.push_back("D"); t_gnt_d = cyc; end
    if (exp_f) begin
      busy = 1; acc_done = 0; fg_m++;
      cur = '{is_d: 0, we: 0, addr: if_addr, wdata: 32'd0, mask: MX};
    end else if (exp_d) begin
      busy = 1; acc_done = 0; dg_m++;
      cur = '{is_d: 1, we: d_we, addr: d_addr, wdata: d_wdata, mask: d_mask};
    end
    if (!if_req || exp_f) streak_m = 0;
    else if (exp_d && streak_m < MAXS) streak_m++;
  endtask

  task automatic drive();
    txn_t t;
    if (gf_s) begin if_req = 0; f_gap = int'($urandom_range(f_gap_max, 0)); end
    if (gd_s) begin d_req = 0; d_gap = int'($urandom_range(d_gap_max, 0)); end
    if (!if_req && fq.size() > 0) begin
      if (f_gap > 0) f_gap--;
      else begin if_req = 1; if_addr = fq.pop_front(); end
    end
    if (!d_req && dq.size() > 0) begin
      if (d_gap > 0) d_gap--;
      else begin
        t = dq.pop_front();
        d_req = 1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_mask = t.mask;
      end
    end
  endtask

  task automatic step();
    @(negedge clk); model();
    @(posedge clk); #1; drive();
  endtask

  task automatic run_quiet(input string tag, input int budget);
    int n = 0;
    while ((fq.size() > 0 || dq.size() > 0 || if_req || d_req || busy) && n < budget) begin
      step(); n++;
    end
    chk({tag, "_complete"}, n < budget, 1);
  endtask

  function automatic txn_t dtx(input logic we, input logic [31:0] a, input logic [31:0] w, input logic [1:0] m);
    return '{is_d: 1, we: we, addr: a, wdata: w, mask: m};
  endfunction

  initial begin
    string exp_ord;
    rst_n = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_mask = MB;
    cyc = 0; busy = 0; acc_done = 0; rv_due = 0; streak_m = 0;
    last_if = '0; last_d = '0; last_mem_addr = '0;

    // Reset state
    step(); step();
    rst_n = 1;

    // Lone fetch, zero-wait memory
    mem_img[32'h100] = 32'h0000_0013;
    en_cnt = 0; if_rv_cnt = 0;
    fq.push_back(32'h100);
    run_quiet("lone_fetch", 50);
    chk("fetch_latency", t_rv_f - t_gnt_f, 3);
    chk("fetch_rdata", if_rdata, 32'h13);
    chk("fetch_mem_addr", last_mem_addr, 32'h100);
    chk("fetch_en_cycles", en_cnt, 1);

    // Byte store with three wait cycles
    rdy_lo = 3; rdy_hi = 3; en_cnt = 0; if_rv_cnt = 0; d_rv_cnt = 0;
    dq.push_back(dtx(1'b1, 32'h2003, 32'hAB, MB));
    run_quiet("byte_store", 50);
    chk("store_en_cycles", en_cnt, 4);
    chk("store_latency", t_rv_d - t_gnt_d, 5);
    chk("store_rdata", d_rdata, 32'd0);
    chk("store_no_if_rvalid", if_rv_cnt, 0);
    chk("store_d_rvalid", d_rv_cnt, 1);

    // Both ports saturated: streak limit lets a fetch through every five grants
    rdy_lo = 0; rdy_hi = 0; gl.delete();
    fq.push_back(32'h1000); fq.push_back(32'h1004);
    for (int i = 0; i < 8; i++) dq.push_back(dtx(1'b0, 32'h3000 + 32'(4 * i), 32'd0, (i % 2 == 0) ? MX : MH));
    run_quiet("streak", 200);
    exp_ord = "DDDDFDDDDF";
    chk("streak_count", gl.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("streak_order%0d", i), (i < gl.size()) ? gl[i] : 8'd0, exp_ord[i]);

    // Back-to-back responses routed to their owners
    mem_img[32'h300] = 32'hDEAD_BEEF; mem_img[32'h404] = 32'h1234_5678;
    if_rv_cnt = 0; d_rv_cnt = 0;
    fq.push_back(32'h300);
    step(); step();
    dq.push_back(dtx(1'b0, 32'h404, 32'd0, MX));
    run_quiet("b2b", 50);
    chk("b2b_if_rvalid", if_rv_cnt, 1);
    chk("b2b_d_rvalid", d_rv_cnt, 1);
    chk("b2b_if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("b2b_d_rdata", d_rdata, 32'h1234_5678);

    // Reset while waiting for read data
    rv_lo = 2; rv_hi = 2;
    fq.push_back(32'h500);
    for (int n = 0; n < 20 && !busy; n++) step();
    dq.push_back(dtx(1'b0, 32'h508, 32'd0, MX));
    fq.push_back(32'h600);
    for (int n = 0; n < 20 && !(busy && acc_done); n++) step();
    #1 rst_n = 0;
    #1;
    chk("async_rst_mem_en", mem_en, 0);
    chk("async_rst_gnt", {if_gnt, d_gnt}, 0);
    chk("async_rst_mask", mem_mask_sel, MX);
    step(); step(); step();
    rst_n = 1; gl.delete(); if_rv_cnt = 0; d_rv_cnt = 0;
    run_quiet("post_rst", 100);
    chk("post_rst_first_gnt", (gl.size() > 0) ? gl[0] : 8'd0, 8'h44);
    chk("post_rst_if_rvalid", if_rv_cnt, 1);
    chk("post_rst_d_rvalid", d_rv_cnt, 1);

    // Randomized traffic with random memory latency and stray mem_ready/mem_rvalid
    noise = 1; rdy_lo = 0; rdy_hi = 3; rv_lo = 1; rv_hi = 3; f_gap_max = 3; d_gap_max = 3;
    for (int i = 0; i < 60; i++) begin
      fq.push_back($urandom & 32'h0000_FFFC);
      dq.push_back(dtx(1'($urandom_range(1, 0)), $urandom & 32'h000F_FFFF, $urandom, 2'($urandom_range(2, 0))));
    end
    run_quiet("random", 5000);

`ifdef RISCV_MEM_ARB_PERF_EN
    // Performance counters after a fresh reset
    noise = 0; rdy_hi = 1; f_gap_max = 0; d_gap_max = 0;
    #1 rst_n = 0;
    step(); step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) fq.push_back(32'h700 + 32'(4 * i));
    dq.push_back(dtx(1'b1, 32'h800, 32'h11, MX));
    dq.push_back(dtx(1'b1, 32'h804, 32'h22, MH));
    run_quiet("perf", 200);
    chk("perf_if_grants", perf_if_grants, 3);
    chk("perf_d_grants", perf_d_grants, 2);
    chk("perf_stall_cycles", perf_stall_cycles, stall_m);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
